alu_arbiter: RTL and testbench

- Shares the single combinational integer unit between two requesters: requester 0 is the execute stage, requester 1 is the address/branch-compare path.
- Selects one request per cycle using round-robin priority and drives the integer unit's operand, op and imm-select inputs.
- Captures the integer unit's result and zero flag in a one-entry registered response stage with valid/ready backpressure.
- Sits between the issue logic and the integer unit. The integer unit itself is instantiated outside this block.

---
 rtl/alu_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter
// ----------------------------------------------------------------------------
// Shares one combinational integer unit between two requesters:
//   requester 0 = execute stage, requester 1 = address/branch-compare path.
// One request is granted per cycle with round-robin priority. The winner's
// operands drive the integer unit, and the result is captured in a one-entry
// registered response stage with valid/ready backpressure.
//
// Optional feature (compile-time macro ALU_OP_CHECK_EN):
//   When defined, the winner's op is checked at accept. An illegal op is still
//   accepted, but the integer unit sees AluAdd instead. The response carries
//   data=0, zero=1, err=1. When undefined, ops pass through unchanged and
//   o_rsp_err is tied to 0.
//
// Ports
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_req_valid/ready     per-requester handshake (bit n = requester n)
//   i_req_op/imm_sel/imm/rs1/rs2/tag   per-requester payload
//   o_iu_*                operands/op to the external integer unit
//   i_iu_res_data/zero    integer unit result (combinational)
//   o_rsp_*               registered response with valid/ready
// ============================================================================
module alu_arbiter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,

    input  logic [1:0]                 i_req_valid,
    output logic [1:0]                 o_req_ready,
    input  logic [1:0][3:0]            i_req_op,
    input  logic [1:0]                 i_req_imm_sel,
    input  logic [1:0][XLEN-1:0]       i_req_imm,
    input  logic [1:0][XLEN-1:0]       i_req_rs1,
    input  logic [1:0][XLEN-1:0]       i_req_rs2,
    input  logic [1:0][TAG_W-1:0]      i_req_tag,

    output logic [3:0]                 o_iu_op,
    output logic                       o_iu_imm_sel,
    output logic [XLEN-1:0]            o_iu_imm,
    output logic [XLEN-1:0]            o_iu_rs1,
    output logic [XLEN-1:0]            o_iu_rs2,
    input  logic [XLEN-1:0]            i_iu_res_data,
    input  logic                       i_iu_res_zero,

    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic                       o_rsp_id,
    output logic [TAG_W-1:0]           o_rsp_tag,
    output logic [XLEN-1:0]            o_rsp_data,
    output logic                       o_rsp_zero,
    output logic                       o_rsp_err
);

    // ------------------------------------------------------------------
    // AluOp encodings (shared with the core's integer unit)
    // ------------------------------------------------------------------
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  ptr_q,       ptr_d;        // requester favoured on contention
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_id_q,    rsp_id_d;
    logic [TAG_W-1:0]      rsp_tag_q,   rsp_tag_d;
    logic [XLEN-1:0]       rsp_data_q,  rsp_data_d;
    logic                  rsp_zero_q,  rsp_zero_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic       can_accept;
    logic [1:0] prio_ok;     // requester would win if it were valid
    logic [1:0] accept;
    logic       any_accept;
    logic       acc_id;
    logic       win_id;

    // The response slot is free when empty or being drained this cycle.
    assign can_accept = !rsp_valid_q || i_rsp_ready;

    // Each ready bit looks only at the *other* requester's valid, so there
    // is never a combinational valid->ready path on the same index. A ready
    // bit may be high for an idle requester; that is harmless because no
    // accept happens without its valid.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign prio_ok[gi]     = !i_req_valid[1-gi] || (ptr_q == 1'(gi));
            assign o_req_ready[gi] = !i_rst && can_accept && prio_ok[gi];
            assign accept[gi]      = i_req_valid[gi] && o_req_ready[gi];
        end
    endgenerate

    // At most one accept bit can be set: with both valid only one side has
    // prio_ok, and with one valid only that side can accept.
    assign any_accept = accept[0] || accept[1];
    assign acc_id     = accept[1];

    // Winner for the operand mux. With no valid request this falls back to
    // requester 0; the integer unit result is then simply not captured.
    assign win_id = i_req_valid[1] && (!i_req_valid[0] || ptr_q);

    // ------------------------------------------------------------------
    // Integer unit drive
    // ------------------------------------------------------------------
    logic [3:0] sel_op;

    always_comb begin
        sel_op       = i_req_op[win_id];
        o_iu_imm_sel = i_req_imm_sel[win_id];
        o_iu_imm     = i_req_imm[win_id];
        o_iu_rs1     = i_req_rs1[win_id];
        o_iu_rs2     = i_req_rs2[win_id];
    end

`ifdef ALU_OP_CHECK_EN
    // ------------------------------------------------------------------
    // Illegal-op screening
    // ------------------------------------------------------------------
    logic op_illegal;
    logic rsp_err_q, rsp_err_d;

    always_comb begin
        op_illegal = 1'b1;
        case (sel_op)
            ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR,
            ALU_OR,  ALU_AND, ALU_SLL, ALU_SRL,  ALU_SRA: op_illegal = 1'b0;
            default:                                      op_illegal = 1'b1;
        endcase
    end

    // Never hand the integer unit an encoding it does not implement.
    assign o_iu_op   = op_illegal ? ALU_ADD : sel_op;
    assign o_rsp_err = rsp_err_q;
`else
    assign o_iu_op   = sel_op;
    assign o_rsp_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Response stage and pointer next-state
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
`ifdef ALU_OP_CHECK_EN
        rsp_err_d   = rsp_err_q;
`endif
        if (any_accept) begin
            // Load (possibly in the same cycle the old response drains).
            rsp_valid_d = 1'b1;
            rsp_id_d    = acc_id;
            rsp_tag_d   = i_req_tag[acc_id];
            rsp_data_d  = i_iu_res_data;
            rsp_zero_d  = i_iu_res_zero;
`ifdef ALU_OP_CHECK_EN
            rsp_err_d   = op_illegal;
            if (op_illegal) begin
                rsp_data_d = '0;
                rsp_zero_d = 1'b1;
            end
`endif
            // Hand priority to the other side even when only one requester
            // is streaming, so a newcomer gets the very next slot.
            ptr_d = !acc_id;
        end else if (i_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b1;
`ifdef ALU_OP_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
`ifdef ALU_OP_CHECK_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_tag   = rsp_tag_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. Includes a behavioural model of the
// external integer unit. Inputs are driven on the falling edge; outputs are
// sampled #1 after either edge.
module tb_alu_arbiter;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][3:0]       req_op;
    logic [1:0]            req_imm_sel;
    logic [1:0][XLEN-1:0]  req_imm;
    logic [1:0][XLEN-1:0]  req_rs1;
    logic [1:0][XLEN-1:0]  req_rs2;
    logic [1:0][TAG_W-1:0] req_tag;
    logic [3:0]            iu_op;
    logic                  iu_imm_sel;
    logic [XLEN-1:0]       iu_imm, iu_rs1, iu_rs2;
    logic [XLEN-1:0]       iu_res_data;
    logic                  iu_res_zero;
    logic                  rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [TAG_W-1:0]      rsp_tag;
    logic [XLEN-1:0]       rsp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_op      (req_op),
        .i_req_imm_sel (req_imm_sel),
        .i_req_imm     (req_imm),
        .i_req_rs1     (req_rs1),
        .i_req_rs2     (req_rs2),
        .i_req_tag     (req_tag),
        .o_iu_op       (iu_op),
        .o_iu_imm_sel  (iu_imm_sel),
        .o_iu_imm      (iu_imm),
        .o_iu_rs1      (iu_rs1),
        .o_iu_rs2      (iu_rs2),
        .i_iu_res_data (iu_res_data),
        .i_iu_res_zero (iu_res_zero),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_id      (rsp_id),
        .o_rsp_tag     (rsp_tag),
        .o_rsp_data    (rsp_data),
        .o_rsp_zero    (rsp_zero),
        .o_rsp_err     (rsp_err)
    );

    // External integer unit model (combinational).
    logic [XLEN-1:0] iu_b;
    always_comb begin
        iu_b        = iu_imm_sel ? iu_imm : iu_rs2;
        iu_res_data = '0;
        case (iu_op)
            ALU_ADD:  iu_res_data = iu_rs1 + iu_b;
            ALU_SUB:  iu_res_data = iu_rs1 - iu_b;
            ALU_SLT:  iu_res_data = {31'd0, $signed(iu_rs1) < $signed(iu_b)};
            ALU_SLTU: iu_res_data = {31'd0, iu_rs1 < iu_b};
            ALU_XOR:  iu_res_data = iu_rs1 ^ iu_b;
            ALU_OR:   iu_res_data = iu_rs1 | iu_b;
            ALU_AND:  iu_res_data = iu_rs1 & iu_b;
            ALU_SLL:  iu_res_data = iu_rs1 << iu_b[4:0];
            ALU_SRL:  iu_res_data = iu_rs1 >> iu_b[4:0];
            ALU_SRA:  iu_res_data = $signed(iu_rs1) >>> iu_b[4:0];
            default:  iu_res_data = '0;
        endcase
        iu_res_zero = (iu_res_data == '0);
    end

    // Protocol monitor: a requester that was valid but not ready must stay
    // valid on the next edge (reset excepted).
    logic [1:0] pend_q = 2'b00;
    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (!rst && pend_q[n] && !req_valid[n]) begin
                errors++;
                $display("FAIL protocol_valid_drop req=%0d got valid=0 want valid=1", n);
            end
        end
        pend_q <= rst ? 2'b00 : (req_valid & ~req_ready);
    end

    task automatic set_req(input int n, input logic [3:0] op, input logic isel,
                           input logic [31:0] imm, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [3:0] tag);
        req_op[n]      = op;
        req_imm_sel[n] = isel;
        req_imm[n]     = imm;
        req_rs1[n]     = rs1;
        req_rs2[n]     = rs2;
        req_tag[n]     = tag;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        set_req(0, ALU_ADD, 1'b0, 32'd0, 32'd1, 32'd1, 4'd9);
        set_req(1, ALU_ADD, 1'b0, 32'd0, 32'd0, 32'd0, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
        checks++;
        if (rsp_zero !== 1'b1 || rsp_data !== 32'd0 || rsp_tag !== 4'd0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_fields got zero=%b data=%h tag=%h id=%b err=%b want 1 0 0 0 0",
                     rsp_zero, rsp_data, rsp_tag, rsp_id, rsp_err);
        end
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_no_accept got valid=%b want 0", rsp_valid); end
        $display("reset: rsp_valid=%b zero=%b", rsp_valid, rsp_zero);
    endtask

    task automatic test_single();
        @(negedge clk);
        set_req(0, ALU_ADD, 1'b0, 32'd0, 32'd5, 32'd7, 4'd3);
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", req_ready); end
        checks++;
        if (iu_rs1 !== 32'd5 || iu_rs2 !== 32'd7 || iu_op !== ALU_ADD) begin
            errors++; $display("FAIL single_iu got rs1=%h rs2=%h op=%h want 5 7 0", iu_rs1, iu_rs2, iu_op);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd12 || rsp_zero !== 1'b0 || rsp_id !== 1'b0 ||
            rsp_tag !== 4'd3 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp got v=%b data=%h zero=%b id=%b tag=%h err=%b want 1 c 0 0 3 0",
                     rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_tag, rsp_err);
        end
        $display("single: id=%b tag=%h data=%h", rsp_id, rsp_tag, rsp_data);
        @(negedge clk);
        req_valid = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got valid=%b want 0", rsp_valid); end
    endtask

    // Pointer is 1 here (after req0's accept); req1 alone wins regardless.
    task automatic test_imm_sltu();
        @(negedge clk);
        set_req(1, ALU_SLTU, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'd5);
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL imm_ready got %b want 10", req_ready); end
        checks++;
        if (iu_imm_sel !== 1'b1 || iu_imm !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL imm_iu got sel=%b imm=%h want 1 ffffffff", iu_imm_sel, iu_imm);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd1 || rsp_id !== 1'b1 || rsp_tag !== 4'd5 || rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL imm_rsp got v=%b data=%h id=%b tag=%h zero=%b want 1 1 1 5 0",
                     rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_zero);
        end
        $display("imm_sltu: id=%b tag=%h data=%h", rsp_id, rsp_tag, rsp_data);
    endtask

    task automatic test_alternate();
        logic       exp_id;
        logic [1:0] exp_ready;
        set_req(0, ALU_SUB, 1'b0, 32'd0, 32'd9, 32'd9, 4'd1);
        set_req(1, ALU_OR,  1'b0, 32'd0, 32'h0F, 32'hF0, 4'd2);
        for (int i = 0; i < 4; i++) begin
            exp_id    = (i % 2) == 1;
            exp_ready = exp_id ? 2'b10 : 2'b01;
            @(negedge clk);
            req_valid = 2'b11;
            #1;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++; $display("FAIL alt_ready[%0d] got %b want %b", i, req_ready, exp_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id ||
                rsp_data !== (exp_id ? 32'hFF : 32'h0) || rsp_zero !== !exp_id ||
                rsp_tag !== (exp_id ? 4'd2 : 4'd1)) begin
                errors++;
                $display("FAIL alt_rsp[%0d] got v=%b id=%b data=%h zero=%b tag=%h want id=%b",
                         i, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_tag, exp_id);
            end
            $display("alternate[%0d]: id=%b data=%h", i, rsp_id, rsp_data);
        end
    endtask

    // Entry: response id1/0xFF held, pointer 0, both requesters valid.
    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rsp_ready = 1'b0;
            #1;
            checks++;
            if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_ready[%0d] got %b want 00", i, req_ready); end
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'hFF || rsp_tag !== 4'd2 || rsp_zero !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d] got v=%b id=%b data=%h tag=%h zero=%b want 1 1 ff 2 0",
                         i, rsp_valid, rsp_id, rsp_data, rsp_tag, rsp_zero);
            end
            $display("stall[%0d]: held id=%b data=%h", i, rsp_id, rsp_data);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL release_ready got %b want 01", req_ready); end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'h0 || rsp_tag !== 4'd1) begin
            errors++;
            $display("FAIL release_refill got v=%b id=%b data=%h tag=%h want 1 0 0 1", rsp_valid, rsp_id, rsp_data, rsp_tag);
        end
        $display("release: id=%b data=%h", rsp_id, rsp_data);
        @(negedge clk); #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL release_next_ready got %b want 10", req_ready); end
        @(posedge clk); #1;
        checks++;
        if (rsp_id !== 1'b1 || rsp_data !== 32'hFF) begin
            errors++; $display("FAIL release_next_rsp got id=%b data=%h want 1 ff", rsp_id, rsp_data);
        end
        @(negedge clk);
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL drain_ready got %b want 01", req_ready); end
        @(posedge clk); #1;
        checks++;
        if (rsp_id !== 1'b0 || rsp_tag !== 4'd1) begin
            errors++; $display("FAIL drain_rsp got id=%b tag=%h want 0 1", rsp_id, rsp_tag);
        end
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    task automatic test_rst_pending();
        @(negedge clk);
        set_req(0, ALU_ADD, 1'b0, 32'd0, 32'd5, 32'd7, 4'd3);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd12) begin
            errors++; $display("FAIL rstp_load got v=%b data=%h want 1 c", rsp_valid, rsp_data);
        end
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_zero !== 1'b1 || rsp_tag !== 4'd0) begin
            errors++;
            $display("FAIL rstp_discard got v=%b data=%h zero=%b tag=%h want 0 0 1 0", rsp_valid, rsp_data, rsp_zero, rsp_tag);
        end
        $display("rst_pending: rsp_valid=%b data=%h", rsp_valid, rsp_data);
        @(negedge clk);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        set_req(1, ALU_OR, 1'b0, 32'd0, 32'h0F, 32'hF0, 4'd2);
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL rstp_ptr got ready=%b want 01", req_ready); end
        @(posedge clk); #1;
        checks++;
        if (rsp_id !== 1'b0 || rsp_data !== 32'd12) begin
            errors++; $display("FAIL rstp_rsp0 got id=%b data=%h want 0 c", rsp_id, rsp_data);
        end
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL rstp_ready1 got %b want 10", req_ready); end
        @(posedge clk); #1;
        checks++;
        if (rsp_id !== 1'b1 || rsp_data !== 32'hFF) begin
            errors++; $display("FAIL rstp_rsp1 got id=%b data=%h want 1 ff", rsp_id, rsp_data);
        end
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    task automatic test_opcheck();
        @(negedge clk);
        set_req(0, 4'hF, 1'b0, 32'd0, 32'd3, 32'd4, 4'd6);
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL opchk_ready got %b want 01", req_ready); end
`ifdef ALU_OP_CHECK_EN
        checks++;
        if (iu_op !== ALU_ADD) begin errors++; $display("FAIL opchk_iu_op got %h want 0", iu_op); end
        @(posedge clk); #1;
        checks++;
        if (rsp_err !== 1'b1 || rsp_data !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 1'b0 || rsp_tag !== 4'd6) begin
            errors++;
            $display("FAIL opchk_rsp got err=%b data=%h zero=%b id=%b tag=%h want 1 0 1 0 6",
                     rsp_err, rsp_data, rsp_zero, rsp_id, rsp_tag);
        end
`else
        checks++;
        if (iu_op !== 4'hF) begin errors++; $display("FAIL opchk_iu_op got %h want f", iu_op); end
        @(posedge clk); #1;
        checks++;
        if (rsp_err !== 1'b0 || rsp_id !== 1'b0 || rsp_tag !== 4'd6 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL opchk_rsp got err=%b id=%b tag=%h v=%b want 0 0 6 1", rsp_err, rsp_id, rsp_tag, rsp_valid);
        end
`endif
        $display("opcheck: err=%b data=%h zero=%b", rsp_err, rsp_data, rsp_zero);
        @(negedge clk);
        req_valid = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL opchk_drain got v=%b want 0", rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_imm_sltu();
        test_alternate();
        test_stall();
        test_rst_pending();
        test_opcheck();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
